led_word_assembler: RTL



---
 rtl/led_word_pkg.sv | 17 +
 rtl/led_byte_shifter.sv | 59 +++++
 rtl/led_word_assembler.sv | 110 +++++++++++
 3 files changed

// File: rtl/led_word_pkg.sv
// Shared types and constants for the LED/status byte-lane word assembler.
//   state_e   : assembler state (COLLECT while gathering bytes, HOLD while a word waits)
//   BYTE_W    : width of one lane byte
//   DEF_BYTES : default bytes per word
//   DEF_CNT_W : default width of the delivered-word counter
package led_word_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DEF_BYTES = 4;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/led_byte_shifter.sv
// BYTES-deep MSB-first byte shift register with a fill index.
// Ports:
//   CLK, RST     : clock, synchronous active-low reset
//   shift_en_i   : shift byte_i in this cycle
//   restart_i    : drop the partial word; byte_i becomes byte 0 (idx -> 1)
//   byte_i       : incoming byte
//   idx_o        : number of bytes currently held
//   last_c       : the next shifted byte completes a word
//   word_c       : shift register value with byte_i shifted into the LSBs
module led_byte_shifter
  import led_word_pkg::*;
#(
  parameter  int unsigned BYTES = DEF_BYTES,
  localparam int unsigned W     = BYTE_W * BYTES,
  localparam int unsigned IDX_W = $clog2(BYTES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              shift_en_i,
  input  logic              restart_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_c,
  output logic [W-1:0]      word_c
);

  logic [W-1:0]     shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign word_c = {shreg_q[W-BYTE_W-1:0], byte_i};
  assign last_c = (idx_q == IDX_W'(BYTES - 1));
  assign idx_o  = idx_q;

  // Next shift register / index; a restart outranks word completion.
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (shift_en_i) begin
      if (restart_i) begin
        shreg_d = W'(byte_i);
        idx_d   = IDX_W'(1);
      end else begin
        shreg_d = word_c;
        idx_d   = last_c ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/led_word_assembler.sv
// Rebuilds BYTES*8-bit words from the 8-bit LED/status byte lane.
// Ports:
//   CLK, RST    : clock, synchronous active-low reset
//   byte_valid  : byte_data valid;  byte_sof: byte is the first of a word
//   byte_data   : incoming byte;    byte_ready: byte accepted this cycle (comb)
//   word_valid  : word_data holds a complete word; word_ready: downstream takes it
//   word_data   : assembled word, first byte in the MSBs
//   frame_err   : one-cycle pulse when a partial word is discarded
//   word_count  : words delivered, wrapping
module led_word_assembler
  import led_word_pkg::*;
#(
  parameter  int unsigned BYTES = DEF_BYTES,
  parameter  int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned W     = BYTE_W * BYTES,
  localparam int unsigned IDX_W = $clog2(BYTES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              byte_valid,
  input  logic              byte_sof,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [W-1:0]      word_data,
  output logic              frame_err,
  output logic [CNT_W-1:0]  word_count
);

  state_e           state_q, state_d;
  logic             word_valid_q, word_valid_d;
  logic [W-1:0]     word_data_q, word_data_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic             byte_acc;
  logic             word_xfer;
  logic             restart;
  logic             last;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     word_next;

  // Handshakes; in HOLD the lane only moves when the held word leaves.
  assign byte_ready = (state_q == HOLD) ? word_ready : 1'b1;
  assign byte_acc   = byte_valid && byte_ready;
  assign word_xfer  = word_valid_q && word_ready;
  // idx is 0 in HOLD, so sof there is a normal first byte.
  assign restart    = byte_sof && (idx != '0);

  led_byte_shifter #(.BYTES(BYTES)) u_shifter (
    .CLK        (CLK),
    .RST        (RST),
    .shift_en_i (byte_acc),
    .restart_i  (restart),
    .byte_i     (byte_data),
    .idx_o      (idx),
    .last_c     (last),
    .word_c     (word_next)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= COLLECT;
    else      state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (byte_acc && !restart && last) state_d = HOLD;
      HOLD:    if (word_ready)                   state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Output next values; BYTES >= 2 so no word completes during a HOLD transfer.
  always_comb begin
    word_valid_d = word_valid_q;
    word_data_d  = word_data_q;
    frame_err_d  = byte_acc && restart;
    word_count_d = word_count_q + CNT_W'(word_xfer);
    if (word_xfer) word_valid_d = 1'b0;
    if ((state_q == COLLECT) && byte_acc && !restart && last) begin
      word_valid_d = 1'b1;
      word_data_d  = word_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      frame_err_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      frame_err_q  <= frame_err_d;
      word_count_q <= word_count_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign frame_err  = frame_err_q;
  assign word_count = word_count_q;

endmodule
